// File: rtl/board_slide_merge.sv
// 2048-style move engine: captures a 4x4 board and then slides and merges one line per cycle.
// The result, moved, win and score are published together with a one-cycle done pulse.
module board_slide_merge (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             dir,
  input  logic [3:0][3:0][11:0]  board_in,
  output logic [3:0][3:0][11:0]  board_out,
  output logic                   busy,
  output logic                   done,
  output logic                   moved,
  output logic                   win,
  output logic [15:0]            score_delta
);

  typedef enum logic [2:0] {
    S_IDLE, S_LINE0, S_LINE1, S_LINE2, S_LINE3, S_DONE
  } state_t;

  state_t                  r_state;
  logic [3:0][3:0][11:0]   r_board;
  logic [1:0]              r_dir;
  logic [15:0]             r_score;
  logic                    r_win;
  logic                    r_moved;

  logic [1:0]              w_idx;
  logic [3:0][11:0]        w_line;
  logic [4:0][11:0]        w_cmp;
  logic [3:0][11:0]        w_res;
  logic [2:0]              w_k;
  logic                    w_skip;
  logic [11:0]             w_sum;
  logic [15:0]             w_sc;
  logic                    w_win;

  // Element 0 of a line is always the edge the tiles slide toward.
  function automatic logic [1:0] cell_row(input logic [1:0] d, input logic [1:0] n,
                                          input logic [1:0] i);
    case (d)
      2'b00:   cell_row = i;
      2'b01:   cell_row = 2'd3 - i;
      default: cell_row = n;
    endcase
  endfunction

  function automatic logic [1:0] cell_col(input logic [1:0] d, input logic [1:0] n,
                                          input logic [1:0] i);
    case (d)
      2'b10:   cell_col = i;
      2'b11:   cell_col = 2'd3 - i;
      default: cell_col = n;
    endcase
  endfunction

  always_comb begin
    case (r_state)
      S_LINE1: w_idx = 2'd1;
      S_LINE2: w_idx = 2'd2;
      S_LINE3: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  always_comb begin
    w_line = '0;
    w_cmp  = '0;
    w_res  = '0;
    w_k    = '0;
    w_skip = 1'b0;
    w_sum  = '0;
    w_sc   = '0;
    w_win  = 1'b0;
    for (int i = 0; i < 4; i++)
      w_line[i] = r_board[cell_row(r_dir, w_idx, 2'(i))][cell_col(r_dir, w_idx, 2'(i))];
    for (int i = 0; i < 4; i++) begin
      if (w_line[i] != 12'd0) begin
        w_cmp[w_k] = w_line[i];
        w_k        = w_k + 3'd1;
      end
    end
    // w_cmp[4] stays zero so the last element never finds a merge partner.
    w_k = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_skip) begin
        w_skip = 1'b0;
      end else if (w_cmp[i] != 12'd0) begin
        if (w_cmp[i] == w_cmp[i+1] && w_cmp[i] != 12'd2048) begin
          w_sum           = w_cmp[i] + w_cmp[i];
          w_res[w_k[1:0]] = w_sum;
          w_sc            = w_sc + {4'd0, w_sum};
          if (w_sum == 12'd2048) w_win = 1'b1;
          w_skip          = 1'b1;
        end else begin
          w_res[w_k[1:0]] = w_cmp[i];
        end
        w_k = w_k + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_dir       <= '0;
      r_score     <= '0;
      r_win       <= 1'b0;
      r_moved     <= 1'b0;
      board_out   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      moved       <= 1'b0;
      win         <= 1'b0;
      score_delta <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_board <= board_in;
            r_dir   <= dir;
            r_score <= '0;
            r_win   <= 1'b0;
            r_moved <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_LINE0;
          end
        end
        S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
          for (int i = 0; i < 4; i++)
            r_board[cell_row(r_dir, w_idx, 2'(i))][cell_col(r_dir, w_idx, 2'(i))] <= w_res[i];
          r_score <= r_score + w_sc;
          r_win   <= r_win | w_win;
          r_moved <= r_moved | (w_res != w_line);
          r_state <= (r_state == S_LINE3) ? S_DONE : state_t'(r_state + 3'd1);
        end
        S_DONE: begin
          board_out   <= r_board;
          moved       <= r_moved;
          win         <= r_win;
          score_delta <= r_score;
          done        <= 1'b1;
          busy        <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_slide_merge.sv
// Directed bench for board_slide_merge: hand-computed moves, timing, start blocking and mid-move reset.
module tb_board_slide_merge;

  typedef logic [3:0][3:0][11:0] brd_t;
  typedef logic [3:0][11:0]      row_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  dir;
  brd_t        board_in;
  brd_t        board_out;
  logic        busy, done, moved, win;
  logic [15:0] score_delta;

  int n_pass = 0;
  int n_tot  = 0;

  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11;

  board_slide_merge dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .board_in(board_in),
    .board_out(board_out), .busy(busy), .done(done), .moved(moved), .win(win),
    .score_delta(score_delta)
  );

  always #5 clk = ~clk;

  function automatic row_t row(input int c0, input int c1, input int c2, input int c3);
    row = {12'(c3), 12'(c2), 12'(c1), 12'(c0)};
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] d, input brd_t b);
    dir      = d;
    board_in = b;
    start    = 1'b1;
  endtask

  // Expects start already driven before the next rising edge (the accepting edge).
  task automatic run_check(input string tag, input brd_t eb, input logic em,
                           input logic ew, input logic [15:0] es);
    @(posedge clk); #1;
    start = 1'b0;
    board_in = '0;
    chk({tag, ".busy_after_accept"}, busy, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, ".done_early"}, done, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy_end"}, busy, 1'b0);
    chk({tag, ".board"}, board_out, eb);
    chk({tag, ".moved"}, moved, em);
    chk({tag, ".win"}, win, ew);
    chk({tag, ".score"}, score_delta, es);
  endtask

  brd_t b, e;
  int   seen_done;

  initial begin
    rst = 1'b1; start = 1'b0; dir = '0; board_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.board", board_out, '0);
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.flags", {moved, win, score_delta}, 18'd0);

    // left [2,2,2,2] -> [4,4,0,0]; start accepted on first edge after reset release
    @(negedge clk);
    rst = 1'b0;
    b = '0; b[0] = row(2, 2, 2, 2);
    e = '0; e[0] = row(4, 4, 0, 0);
    drive(LEFT, b);
    run_check("left4", e, 1'b1, 1'b0, 16'd8);

    // back-to-back: right [2,2,4,0] -> [0,0,4,4], no chained 8
    @(negedge clk);
    b = '0; b[1] = row(2, 2, 4, 0);
    e = '0; e[1] = row(0, 0, 4, 4);
    drive(RIGHT, b);
    run_check("right", e, 1'b1, 1'b0, 16'd4);

    // up col2 [4,0,4,8] -> [8,8,0,0]
    @(negedge clk);
    b = '0; b[0][2] = 12'd4; b[2][2] = 12'd4; b[3][2] = 12'd8;
    e = '0; e[0][2] = 12'd8; e[1][2] = 12'd8;
    drive(UP, b);
    run_check("up", e, 1'b1, 1'b0, 16'd8);

    // down 1024+1024 -> 2048 in row3
    @(negedge clk);
    b = '0; b[2][0] = 12'd1024; b[3][0] = 12'd1024;
    e = '0; e[3][0] = 12'd2048;
    drive(DOWN, b);
    run_check("down_win", e, 1'b1, 1'b1, 16'd2048);

    // 2048 pair never merges, nothing moves
    @(negedge clk);
    b = '0; b[0] = row(2048, 2048, 0, 0);
    drive(LEFT, b);
    run_check("no_move", b, 1'b0, 1'b0, 16'd0);

    // fresh 2048 does not chain into an existing 2048
    @(negedge clk);
    b = '0; b[0] = row(1024, 1024, 2048, 0);
    e = '0; e[0] = row(2048, 2048, 0, 0);
    drive(LEFT, b);
    run_check("no_chain2048", e, 1'b1, 1'b1, 16'd2048);

    // several rows at once
    @(negedge clk);
    b = '0;
    b[0] = row(0, 0, 0, 2); b[1] = row(2, 4, 2, 4);
    b[2] = row(0, 2, 0, 2); b[3] = row(8, 0, 8, 8);
    e = '0;
    e[0] = row(2, 0, 0, 0); e[1] = row(2, 4, 2, 4);
    e[2] = row(4, 0, 0, 0); e[3] = row(16, 8, 0, 0);
    drive(LEFT, b);
    run_check("multi", e, 1'b1, 1'b0, 16'd20);

    // start pulsed during LINE2 must be ignored
    @(negedge clk);
    b = '0; b[0] = row(4, 4, 0, 0);
    e = '0; e[0] = row(8, 0, 0, 0);
    drive(LEFT, b);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b = '0; b[0] = row(2, 2, 0, 0);
    drive(RIGHT, b);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ign.done_early", done, 1'b0);
    @(posedge clk); #1;
    chk("ign.done", done, 1'b1);
    chk("ign.board", board_out, e);
    chk("ign.score", score_delta, 16'd8);
    @(posedge clk); #1;
    chk("ign.done_pulse", done, 1'b0);
    chk("ign.no_restart", busy, 1'b0);

    // reset during LINE1 abandons the move
    @(negedge clk);
    b = '0; b[3] = row(2, 2, 0, 0);
    drive(LEFT, b);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst.board", board_out, '0);
    chk("rst.busy", busy, 1'b0);
    seen_done = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    chk("rst.no_done", 32'(seen_done), 32'd0);
    chk("rst.flags", {moved, win, score_delta}, 18'd0);

    // restart straight out of reset
    @(negedge clk);
    rst = 1'b0;
    b = '0; b[3] = row(0, 2, 0, 2);
    e = '0; e[3] = row(0, 0, 0, 4);
    drive(RIGHT, b);
    run_check("after_rst", e, 1'b1, 1'b0, 16'd4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
